// File: rtl/fifo_reader.sv
// fifo_reader: drains a read-latency-1 FIFO into a 3-entry output buffer with valid/ready handshake.
// Define FIFO_READER_STATS_EN to add a 16-bit delivered-word counter on rd_count.
module fifo_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  empty,
    input  logic                  underflow,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           rd_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [1:0] LAST_SLOT = 2'(BUF_DEPTH - 1);

    state_t                state;
    state_t                state_next;
    logic                  pending;
    logic [1:0]            occ;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [FIFO_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic                  capture;
    logic                  pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == LAST_SLOT) ? 2'd0 : ptr + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (en) state_next = RUN;
            RUN:  if (!en) state_next = STOP;
            STOP: begin
                if (en) begin
                    state_next = RUN;
                end else if (!pending) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Room check counts the in-flight read so the buffer can never be overrun.
    assign rd_en   = (state == RUN) && !empty
                   && (({1'b0, occ} + {2'b00, pending}) < 3'(BUF_DEPTH));
    assign capture = pending && !underflow;
    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_data  = buf_mem[rd_ptr];
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 1'b0;
            occ     <= 2'd0;
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            err     <= 1'b0;
        end else begin
            pending <= rd_en;
            if (capture) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (capture && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !capture) begin
                occ <= occ - 2'd1;
            end
            if (pending && underflow) begin
                err <= 1'b1;
            end
        end
    end

    // NOTE: buffer storage is deliberately not reset; occ gates m_valid, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_mem[wr_ptr] <= data_out;
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [15:0] pop_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pop_count <= 16'd0;
        end else if (pop) begin
            pop_count <= pop_count + 16'd1;
        end
    end

    assign rd_count = pop_count;
`else
    assign rd_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: a queue-based FIFO model feeds the DUT and a scoreboard
// checks delivered words, ordering, handshake timing, error stickiness and reset behaviour.
module tb_fifo_reader;

    localparam int W = 16;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         en        = 1'b0;
    logic         empty     = 1'b1;
    logic         underflow = 1'b0;
    logic         m_ready   = 1'b0;
    logic [W-1:0] data_out  = '0;
    logic         rd_en;
    logic         m_valid;
    logic         busy;
    logic         err;
    logic [W-1:0] m_data;
    logic [15:0]  rd_count;

    always #5 clk = ~clk;

    fifo_reader #(.FIFO_WIDTH(W), .BUF_DEPTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .empty     (empty),
        .underflow (underflow),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .err       (err),
        .rd_count  (rd_count)
    );

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] fifo_q [$];
    logic [W-1:0] exp_q  [$];
    int           pop_cyc [$];
    int           rd_cyc  [$];
    logic         inflight    = 1'b0;
    logic         inflight_uf = 1'b0;
    logic [W-1:0] inflight_w  = '0;
    logic         force_uf    = 1'b0;
    logic         feed        = 1'b0;
    logic         err_exp     = 1'b0;
    logic [15:0]  stat_cnt    = 16'd0;
    int           cyc         = 0;
    int           rd_pulses   = 0;
    int           pops        = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] count_exp();
`ifdef FIFO_READER_STATS_EN
        return stat_cnt;
`else
        return 16'd0;
`endif
    endfunction

    // One clock: sample/check at negedge, advance the FIFO and scoreboard at posedge, drive at +1.
    task automatic tick();
        logic rs;
        logic ps;
        @(negedge clk);
        rs = rd_en;
        ps = m_valid && m_ready;
        if (rst_n) begin
            check("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
            check("err", 32'(err), 32'(err_exp));
            check("rd_count", 32'(rd_count), 32'(count_exp()));
            if (rs) begin
                check("rd_en_safe", 32'(empty || ((exp_q.size() + int'(inflight)) >= 3)), 32'd0);
                rd_cyc.push_back(cyc);
            end
            if (ps && exp_q.size() != 0) begin
                check("m_data", 32'(m_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                pop_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        if (rs) rd_pulses++;
        if (!rst_n) begin
            exp_q.delete();
            err_exp  = 1'b0;
            stat_cnt = 16'd0;
        end else begin
            if (inflight) begin
                if (inflight_uf) err_exp = 1'b1;
                else             exp_q.push_back(inflight_w);
            end
            if (ps) begin
                stat_cnt++;
                pops++;
            end
        end
        inflight = rs && rst_n;
        if (rs) begin
            if (fifo_q.size() != 0) begin
                inflight_w  = fifo_q.pop_front();
                inflight_uf = force_uf;
                force_uf    = 1'b0;
            end else begin
                inflight_uf = 1'b1;
            end
        end
        #1;
        if (feed && fifo_q.size() < 4) begin
            for (int i = 0; i < 4; i++) fifo_q.push_back(16'($urandom));
        end
        data_out  = inflight_w;
        underflow = inflight && inflight_uf;
        empty     = (fifo_q.size() == 0);
        #1;
    endtask

    task automatic load(input logic [W-1:0] word);
        fifo_q.push_back(word);
        empty = 1'b0;
    endtask

    task automatic do_reset();
        en       = 1'b0;
        m_ready  = 1'b0;
        force_uf = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        fifo_q.delete();
        empty = 1'b1;
        rd_pulses = 0;
        pops      = 0;
        pop_cyc.delete();
        rd_cyc.delete();
    endtask

    initial begin
        logic [W-1:0] w [8];

        // Reset state, sampled while rst_n is still low after a reset edge.
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);

        // Five words streamed back-to-back with m_ready held high.
        do_reset();
        for (int i = 1; i <= 5; i++) load(16'(i));
        en = 1'b1;
        m_ready = 1'b1;
        tick();
        check("t1_first_rd", 32'(rd_en), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 20 && pops < 5; i++) tick();
        check("t1_pops", 32'(pops), 32'd5);
        if (pop_cyc.size() == 5 && rd_cyc.size() != 0) begin
            check("t1_back_to_back", 32'(pop_cyc[4] - pop_cyc[0]), 32'd4);
            check("t1_latency", 32'(pop_cyc[0] - rd_cyc[0]), 32'd2);
        end
`ifdef FIFO_READER_STATS_EN
        check("t1_rd_count", 32'(rd_count), 32'd5);
`else
        check("t1_rd_count", 32'(rd_count), 32'd0);
`endif
        en = 1'b0;
        for (int i = 0; i < 10 && busy; i++) tick();
        check("t1_idle", 32'(busy), 32'd0);

        // Backpressure: buffer fills to three, head held, then all eight drain in order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w[i] = 16'($urandom);
            load(w[i]);
        end
        en = 1'b1;
        repeat (10) tick();
        check("t2_rd_pulses", 32'(rd_pulses), 32'd3);
        check("t2_m_valid", 32'(m_valid), 32'd1);
        check("t2_head_held", 32'(m_data), 32'(w[0]));
        check("t2_no_rd_full", 32'(rd_en), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 40 && pops < 8; i++) tick();
        check("t2_pops", 32'(pops), 32'd8);
        check("t2_fifo_drained", 32'(fifo_q.size()), 32'd0);
        en = 1'b0;
        repeat (4) tick();

        // Drop en on the cycle rd_en fires: pending word still lands, then IDLE with no more reads.
        do_reset();
        for (int i = 0; i < 4; i++) load(16'h0a00 + 16'(i));
        en = 1'b1;
        m_ready = 1'b1;
        tick();
        check("t3_rd_en", 32'(rd_en), 32'd1);
        en = 1'b0;
        tick();
        check("t3_stop_busy", 32'(busy), 32'd1);
        check("t3_stop_no_rd", 32'(rd_en), 32'd0);
        tick();
        tick();
        check("t3_idle", 32'(busy), 32'd0);
        repeat (4) tick();
        check("t3_rd_pulses", 32'(rd_pulses), 32'd1);
        check("t3_pops", 32'(pops), 32'd1);

        // Underflow on the first pending cycle: word dropped, err sticky.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w[i] = 16'($urandom);
            load(w[i]);
        end
        force_uf = 1'b1;
        en = 1'b1;
        repeat (10) tick();
        check("t4_err", 32'(err), 32'd1);
        check("t4_rd_pulses", 32'(rd_pulses), 32'd3);
        check("t4_m_valid", 32'(m_valid), 32'd1);
        check("t4_head", 32'(m_data), 32'(w[1]));
        m_ready = 1'b1;
        repeat (5) tick();
        check("t4_pops", 32'(pops), 32'd2);
        check("t4_err_sticky", 32'(err), 32'd1);
        en = 1'b0;
        repeat (3) tick();

        // Reset with two buffered words and one read in flight (err already set).
        do_reset();
        for (int i = 0; i < 6; i++) load(16'($urandom));
        force_uf = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 20 && !(rd_pulses >= 2 && !rd_en); i++) tick();
        check("t5_rd_pulses", 32'(rd_pulses), 32'd4);
        check("t5_err_pre", 32'(err), 32'd1);
        check("t5_m_valid_pre", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("t5_m_valid", 32'(m_valid), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rd_en", 32'(rd_en), 32'd0);
        rst_n = 1'b1;
        en = 1'b0;
        m_ready = 1'b1;
        repeat (4) tick();
        check("t5_no_stale", 32'(pops), 32'd0);

        // Randomised en / m_ready / occasional underflow against the scoreboard.
        do_reset();
        for (int i = 0; i < 40; i++) load(16'($urandom));
        for (int i = 0; i < 300; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) force_uf = 1'b1;
            tick();
        end
        force_uf = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 200 && (fifo_q.size() != 0 || exp_q.size() != 0 || inflight); i++) tick();
        check("t6_drained", 32'(fifo_q.size() + exp_q.size()), 32'd0);
        en = 1'b0;
        repeat (4) tick();

`ifdef FIFO_READER_STATS_EN
        // Counter wrap: 65537 pops leave rd_count at 1.
        do_reset();
        feed = 1'b1;
        load(16'h1234);
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 70000 && pops < 65537; i++) tick();
        feed = 1'b0;
        check("t7_pops", 32'(pops), 32'd65537);
        check("t7_rd_count_wrap", 32'(rd_count), 32'd1);
        en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
